// File: rtl/blink_operand_loader.sv
// Operand loader for the Blink-64 cipher core: collects narrow stream words into the
// K0/K1/T/P operand registers and issues them to the core through a valid/ready handshake.
module blink_operand_loader #(
    parameter int W      = 32,
    parameter int N      = 64,
    parameter int ROUNDS = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     in_key,
    input  logic                     in_enc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     enc,
    output logic [N*ROUNDS/2-1:0]    K0,
    output logic [2*(2*N-1)-1:0]     K1,
    output logic [N-1:0]             T,
    output logic [N-1:0]             P,
    output logic                     key_loaded,
    output logic                     err_nokey
);

    localparam int K0_BITS = N * ROUNDS / 2;
    localparam int K1_BITS = 2 * (2 * N - 1);
    localparam int K0W     = K0_BITS / W;
    localparam int K1W     = (K1_BITS + W - 1) / W;
    localparam int TW      = N / W;
    localparam int PW      = N / W;
    localparam int K1_TAIL = K1_BITS - (K1W - 1) * W;
    localparam int CW      = $clog2(K0W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_K0 = 3'd1,
        LD_K1 = 3'd2,
        LD_T  = 3'd3,
        LD_P  = 3'd4,
        ISSUE = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 enc_q, enc_d;
    logic [K0_BITS-1:0]   k0_q, k0_d;
    logic [K1_BITS-1:0]   k1_q, k1_d;
    logic [N-1:0]         t_q, t_d;
    logic [N-1:0]         p_q, p_d;
    logic                 key_loaded_q, key_loaded_d;
    logic                 err_nokey_q, err_nokey_d;
    logic                 in_ready_q, in_ready_d;

    logic                 hs;
    logic                 wr_k0, wr_k1, wr_t, wr_p;

    assign hs = in_valid && in_ready_q;

    // NOTE: every variable gets its default before the case so that no path leaves a
    // value unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        enc_d        = enc_q;
        key_loaded_d = key_loaded_q;
        err_nokey_d  = 1'b0;
        wr_k0        = 1'b0;
        wr_k1        = 1'b0;
        wr_t         = 1'b0;
        wr_p         = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    enc_d   = in_enc;
                    count_d = CW'(1);
                    if (in_key) begin
                        wr_k0   = 1'b1;
                        state_d = LD_K0;
                    end else begin
                        wr_t        = 1'b1;
                        state_d     = LD_T;
                        err_nokey_d = !key_loaded_q;
                    end
                end
            end
            LD_K0: begin
                if (hs) begin
                    wr_k0 = 1'b1;
                    if (count_q == CW'(K0W - 1)) begin
                        count_d = '0;
                        state_d = LD_K1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            LD_K1: begin
                if (hs) begin
                    wr_k1 = 1'b1;
                    if (count_q == CW'(K1W - 1)) begin
                        count_d      = '0;
                        state_d      = LD_T;
                        key_loaded_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            LD_T: begin
                if (hs) begin
                    wr_t = 1'b1;
                    if (count_q == CW'(TW - 1)) begin
                        count_d = '0;
                        state_d = LD_P;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            LD_P: begin
                if (hs) begin
                    wr_p = 1'b1;
                    if (count_q == CW'(PW - 1)) begin
                        count_d = '0;
                        state_d = ISSUE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        in_ready_d = (state_d != ISSUE);
    end

    // Word steering: the active field's write strobe plus count select one word slot.
    always_comb begin
        k0_d = k0_q;
        k1_d = k1_q;
        t_d  = t_q;
        p_d  = p_q;

        for (int j = 0; j < K0W; j++) begin
            if (wr_k0 && count_q == CW'(j)) begin
                k0_d[j*W +: W] = in_data;
            end
        end
        for (int j = 0; j < K1W - 1; j++) begin
            if (wr_k1 && count_q == CW'(j)) begin
                k1_d[j*W +: W] = in_data;
            end
        end
        // The last K1 word carries more bits than the field holds; its top bits are dropped.
        if (wr_k1 && count_q == CW'(K1W - 1)) begin
            k1_d[K1_BITS-1 -: K1_TAIL] = in_data[K1_TAIL-1:0];
        end
        for (int j = 0; j < TW; j++) begin
            if (wr_t && count_q == CW'(j)) begin
                t_d[j*W +: W] = in_data;
            end
        end
        for (int j = 0; j < PW; j++) begin
            if (wr_p && count_q == CW'(j)) begin
                p_d[j*W +: W] = in_data;
            end
        end
    end

    // NOTE: the operand registers are reset along with the control state so that a reset
    // mid-frame leaves no stale key material visible on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            enc_q        <= 1'b0;
            k0_q         <= '0;
            k1_q         <= '0;
            t_q          <= '0;
            p_q          <= '0;
            key_loaded_q <= 1'b0;
            err_nokey_q  <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            count_q      <= count_d;
            enc_q        <= enc_d;
            k0_q         <= k0_d;
            k1_q         <= k1_d;
            t_q          <= t_d;
            p_q          <= p_d;
            key_loaded_q <= key_loaded_d;
            err_nokey_q  <= err_nokey_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q == ISSUE);
    assign enc        = enc_q;
    assign K0         = k0_q;
    assign K1         = k1_q;
    assign T          = t_q;
    assign P          = p_q;
    assign key_loaded = key_loaded_q;
    assign err_nokey  = err_nokey_q;

endmodule

// File: tb/tb_blink_operand_loader.sv
// Self-checking bench for blink_operand_loader: table of frames plus hand-written
// corner sequences, with a scoreboard queue of expected operand sets.
module tb_blink_operand_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid, in_ready, in_key, in_enc;
    logic [31:0]  in_data;
    logic         out_valid, out_ready, enc, key_loaded, err_nokey;
    logic [447:0] K0;
    logic [253:0] K1;
    logic [63:0]  T, P;

    always #5 clk = ~clk;

    blink_operand_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_enc     (in_enc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .enc        (enc),
        .K0         (K0),
        .K1         (K1),
        .T          (T),
        .P          (P),
        .key_loaded (key_loaded),
        .err_nokey  (err_nokey)
    );

    typedef struct {
        logic         enc;
        logic [447:0] k0;
        logic [253:0] k1;
        logic [63:0]  t;
        logic [63:0]  p;
    } exp_t;

    typedef struct {
        logic        key;
        logic        enc;
        logic [31:0] base;
        bit          gaps;
    } frame_t;

    int           vectors    = 0;
    int           miscompares = 0;
    int           err_count  = 0;
    exp_t         sb_q[$];
    exp_t         mon_e;
    frame_t       frames[6];
    logic [447:0] m_k0;
    logic [253:0] m_k1;
    logic         m_key_loaded;

    task automatic check(input string name, input logic [447:0] act, input logic [447:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && err_nokey) err_count++;
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue", out_valid, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check("issue_enc", enc, mon_e.enc);
                check("issue_K0", K0, mon_e.k0);
                check("issue_K1", K1, mon_e.k1);
                check("issue_T", T, mon_e.t);
                check("issue_P", P, mon_e.p);
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic key, input logic en);
        bit took = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = key;
        in_enc   = en;
        for (int c = 0; c < 200 && !took; c++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!took) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic send_frame(input logic key, input logic en, input logic [31:0] base, input bit gaps);
        int           n;
        int           f;
        int           err_before;
        logic         exp_err;
        logic [255:0] k1x;
        logic [31:0]  w;
        exp_t         e;
        n          = key ? 26 : 4;
        exp_err    = !key && !m_key_loaded;
        err_before = err_count;
        k1x        = {2'b00, m_k1};
        for (int i = 0; i < n; i++) begin
            w = base + 32'(i);
            f = key ? i : i + 22;
            if (f < 14)      m_k0[f*32 +: 32] = w;
            else if (f < 22) k1x[(f-14)*32 +: 32] = w;
            else if (f < 24) e.t[(f-22)*32 +: 32] = w;
            else             e.p[(f-24)*32 +: 32] = w;
        end
        m_k1 = k1x[253:0];
        if (key) m_key_loaded = 1'b1;
        e.enc = en;
        e.k0  = m_k0;
        e.k1  = m_k1;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (i == n - 1) sb_q.push_back(e);
            send_word(base + 32'(i), key, en);
        end
        check("err_nokey_pulses", 448'(err_count - err_before), exp_err);
        check("key_loaded", key_loaded, m_key_loaded);
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && sb_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d operand sets never issued, required 0", sb_q.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_enc", enc, 1'b0);
        check("rst_K0", K0, '0);
        check("rst_K1", K1, '0);
        check("rst_T", T, '0);
        check("rst_P", P, '0);
        check("rst_key_loaded", key_loaded, 1'b0);
        check("rst_err_nokey", err_nokey, 1'b0);
        m_k0         = '0;
        m_k1         = '0;
        m_key_loaded = 1'b0;
        sb_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_key_loaded", key_loaded, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        frames[0] = '{key: 1'b0, enc: 1'b0, base: 32'h0000_00A0, gaps: 1'b0};
        frames[1] = '{key: 1'b1, enc: 1'b0, base: 32'h0000_1000, gaps: 1'b1};
        frames[2] = '{key: 1'b0, enc: 1'b1, base: 32'hDEAD_0000, gaps: 1'b1};
        frames[3] = '{key: 1'b0, enc: 1'b0, base: 32'hFFFF_FFFC, gaps: 1'b0};
        frames[4] = '{key: 1'b1, enc: 1'b1, base: 32'h8000_0000, gaps: 1'b0};
        frames[5] = '{key: 1'b0, enc: 1'b1, base: 32'h0000_0055, gaps: 1'b1};

        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = 1'b0;
        in_enc    = 1'b0;
        out_ready = 1'b1;
        apply_reset();

        // Key frame with word index as data, then spot-check the field boundaries.
        send_frame(1'b1, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        check("s2_out_valid", out_valid, 1'b1);
        check("s2_K0_lo", K0[31:0], 32'd0);
        check("s2_K0_hi", K0[447:416], 32'd13);
        check("s2_K1_lo", K1[31:0], 32'd14);
        check("s2_K1_hi", K1[253:224], 30'd21);
        check("s2_T", T, {32'd23, 32'd22});
        check("s2_P", P, {32'd25, 32'd24});
        check("s2_enc", enc, 1'b1);
        check("s2_key_loaded", key_loaded, 1'b1);
        @(posedge clk);
        #1;

        foreach (frames[i]) begin
            send_frame(frames[i].key, frames[i].enc, frames[i].base, frames[i].gaps);
        end
        drain();

        // Back-pressure in ISSUE while upstream keeps offering a word.
        out_ready = 1'b0;
        send_frame(1'b0, 1'b1, 32'h0000_7000, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        in_key   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_T", T, sb_q[0].t);
            check("hold_P", P, sb_q[0].p);
            check("hold_K0", K0, sb_q[0].k0);
            check("hold_enc", enc, sb_q[0].enc);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_issue_out_valid", out_valid, 1'b0);
        check("post_issue_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        send_frame(1'b0, 1'b0, 32'h0000_8000, 1'b0);
        drain();

        // Data-only frames with no key since reset.
        apply_reset();
        send_frame(1'b0, 1'b1, 32'h0000_00C0, 1'b0);
        send_frame(1'b0, 1'b0, 32'h0000_00D0, 1'b1);
        drain();

        // Reset after word 10 of a key frame, then a complete key frame.
        for (int i = 0; i < 11; i++) begin
            send_word(32'h5000 + 32'(i), 1'b1, 1'b1);
        end
        apply_reset();
        send_frame(1'b1, 1'b0, 32'h0000_0100, 1'b1);
        drain();

        // Same key frame as the first, now with random valid gaps.
        send_frame(1'b1, 1'b1, 32'd0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
